// File: rtl/icache_pkg.sv
// -----------------------------------------------------------------------------
// icache_pkg
// Shared definitions for the instruction cache: refill FSM state encoding,
// default geometry and helpers that derive address-field widths from the
// cache geometry.
// -----------------------------------------------------------------------------
package icache_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StRefillReq = 2'd1,
        StRefillGap = 2'd2
    } refill_state_e;

    localparam int unsigned AddrW               = 32;
    localparam int unsigned DefaultNumLines     = 64;
    localparam int unsigned DefaultWordsPerLine = 4;

    // Word-select width inside a line.
    function automatic int unsigned off_bits(input int unsigned words_per_line);
        return $clog2(words_per_line);
    endfunction

    // Line-index width.
    function automatic int unsigned idx_bits(input int unsigned num_lines);
        return $clog2(num_lines);
    endfunction

    // Line-number width: everything above the word-select field.
    function automatic int unsigned line_bits(input int unsigned words_per_line);
        return AddrW - 2 - off_bits(words_per_line);
    endfunction

    // Tag width: everything above the index field.
    function automatic int unsigned tag_bits(input int unsigned num_lines,
                                             input int unsigned words_per_line);
        return AddrW - 2 - off_bits(words_per_line) - idx_bits(num_lines);
    endfunction

endpackage

// File: rtl/icache_refill_fsm.sv
// -----------------------------------------------------------------------------
// icache_refill_fsm
// Sequences a line refill as one-word requests on the memory port.
//   clk, rst_n    : clock, asynchronous active-low reset
//   i_start       : miss detected in IDLE; latch i_line and begin refill
//   i_line        : line number (byte address >> (2+OFF)) of the missing line
//   i_mem_ready   : refill word valid (sampled only in REFILL_REQ)
//   o_idle        : FSM is in IDLE (lookups allowed)
//   o_we          : write i_mem_rdata into the line this cycle
//   o_last        : current beat is the final word of the line
//   o_beat        : word slot being fetched
//   o_line        : latched line number of the refill
//   o_mem_req     : registered refill request
//   o_mem_addr    : registered word-aligned refill address
// -----------------------------------------------------------------------------
module icache_refill_fsm
    import icache_pkg::*;
#(
    parameter int unsigned WORDS_PER_LINE = DefaultWordsPerLine,
    localparam int unsigned OffW          = off_bits(WORDS_PER_LINE),
    localparam int unsigned LineW         = line_bits(WORDS_PER_LINE)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_start,
    input  logic [LineW-1:0] i_line,
    input  logic             i_mem_ready,
    output logic             o_idle,
    output logic             o_we,
    output logic             o_last,
    output logic [OffW-1:0]  o_beat,
    output logic [LineW-1:0] o_line,
    output logic             o_mem_req,
    output logic [31:0]      o_mem_addr
);

    refill_state_e    r_state;
    logic [OffW-1:0]  r_beat;
    logic [LineW-1:0] r_line;
    logic             r_mem_req;
    logic [31:0]      r_mem_addr;

    logic w_last;
    logic w_accept;

    assign w_last   = (r_beat == OffW'(WORDS_PER_LINE - 1));
    // Ready is only meaningful while a request is outstanding; in the gap
    // cycle it may still carry the previous beat's flag.
    assign w_accept = (r_state == StRefillReq) && i_mem_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StIdle;
            r_beat     <= '0;
            r_line     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_line     <= i_line;
                        r_beat     <= '0;
                        r_mem_addr <= {i_line, {(OffW + 2){1'b0}}};
                        r_mem_req  <= 1'b1;
                        r_state    <= StRefillReq;
                    end
                end
                StRefillReq: begin
                    if (w_accept) begin
                        r_mem_req <= 1'b0;
                        if (w_last) begin
                            r_state <= StIdle;
                        end else begin
                            r_beat     <= r_beat + 1'b1;
                            r_mem_addr <= r_mem_addr + 32'd4;
                            r_state    <= StRefillGap;
                        end
                    end
                end
                StRefillGap: begin
                    r_mem_req <= 1'b1;
                    r_state   <= StRefillReq;
                end
                default: begin
                    r_mem_req <= 1'b0;
                    r_state   <= StIdle;
                end
            endcase
        end
    end

    assign o_idle     = (r_state == StIdle);
    assign o_we       = w_accept;
    assign o_last     = w_last;
    assign o_beat     = r_beat;
    assign o_line     = r_line;
    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;

endmodule

// File: rtl/instruction_cache.sv
// -----------------------------------------------------------------------------
// instruction_cache
// Direct-mapped read-only instruction cache. Hits return data combinationally;
// misses stall fetch while icache_refill_fsm refills the whole line.
//   clk, rst_n   : clock, asynchronous active-low reset
//   i_cpu_req    : fetch request valid
//   i_cpu_addr   : fetch byte address (bits [1:0] ignored)
//   o_cpu_rdata  : instruction word (0 when not hit)
//   o_cpu_ready  : hit this cycle
//   i_flush      : single-cycle pulse, invalidate all lines
//   o_mem_addr   : word-aligned refill address
//   o_mem_req    : refill request
//   i_mem_rdata  : refill data
//   i_mem_ready  : refill word valid
// -----------------------------------------------------------------------------
module instruction_cache
    import icache_pkg::*;
#(
    parameter int unsigned NUM_LINES      = DefaultNumLines,
    parameter int unsigned WORDS_PER_LINE = DefaultWordsPerLine
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_cpu_req,
    input  logic [31:0] i_cpu_addr,
    output logic [31:0] o_cpu_rdata,
    output logic        o_cpu_ready,
    input  logic        i_flush,
    output logic [31:0] o_mem_addr,
    output logic        o_mem_req,
    input  logic [31:0] i_mem_rdata,
    input  logic        i_mem_ready
);

    localparam int unsigned OffW  = off_bits(WORDS_PER_LINE);
    localparam int unsigned IdxW  = idx_bits(NUM_LINES);
    localparam int unsigned TagW  = tag_bits(NUM_LINES, WORDS_PER_LINE);
    localparam int unsigned LineW = line_bits(WORDS_PER_LINE);

    logic [NUM_LINES-1:0] r_valid;
    logic                 r_flush_pending;
    logic [TagW-1:0]      r_tag  [NUM_LINES];
    logic [31:0]          r_data [NUM_LINES*WORDS_PER_LINE];

    logic [OffW-1:0]  w_word;
    logic [IdxW-1:0]  w_idx;
    logic [TagW-1:0]  w_tag;
    logic [LineW-1:0] w_line;
    logic             w_hit_raw;
    logic             w_flush_now;
    logic             w_start;
    logic             w_idle;
    logic             w_we;
    logic             w_last;
    logic [OffW-1:0]  w_beat;
    logic [LineW-1:0] w_fill_line;
    logic [IdxW-1:0]  w_fill_idx;
    logic [TagW-1:0]  w_fill_tag;
    logic             unused_addr_lsb;

    assign unused_addr_lsb = ^i_cpu_addr[1:0];

    assign w_word = i_cpu_addr[2+OffW-1:2];
    assign w_idx  = i_cpu_addr[2+OffW+IdxW-1:2+OffW];
    assign w_tag  = i_cpu_addr[31 -: TagW];
    assign w_line = i_cpu_addr[31 -: LineW];

    assign w_fill_idx = w_fill_line[IdxW-1:0];
    assign w_fill_tag = w_fill_line[LineW-1 -: TagW];

    // A flush (fresh or deferred from a refill) owns the IDLE cycle it lands
    // in: no hit is reported and no new refill is started.
    assign w_flush_now = i_flush | r_flush_pending;
    assign w_hit_raw   = w_idle & i_cpu_req & r_valid[w_idx] & (r_tag[w_idx] == w_tag);
    assign w_start     = w_idle & i_cpu_req & ~w_hit_raw & ~w_flush_now;

    assign o_cpu_ready = w_hit_raw & ~w_flush_now;
    assign o_cpu_rdata = o_cpu_ready ? r_data[{w_idx, w_word}] : 32'd0;

    icache_refill_fsm #(
        .WORDS_PER_LINE (WORDS_PER_LINE)
    ) u_refill_fsm (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_start     (w_start),
        .i_line      (w_line),
        .i_mem_ready (i_mem_ready),
        .o_idle      (w_idle),
        .o_we        (w_we),
        .o_last      (w_last),
        .o_beat      (w_beat),
        .o_line      (w_fill_line),
        .o_mem_req   (o_mem_req),
        .o_mem_addr  (o_mem_addr)
    );

    // Valid bits and the deferred-flush flag. A flush in IDLE wins over
    // everything; the install of the final beat happens outside IDLE so the
    // two never collide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid         <= '0;
            r_flush_pending <= 1'b0;
        end else if (w_idle && w_flush_now) begin
            r_valid         <= '0;
            r_flush_pending <= 1'b0;
        end else begin
            if (i_flush) begin
                r_flush_pending <= 1'b1;
            end
            if (w_we && w_last) begin
                r_valid[w_fill_idx] <= 1'b1;
            end
        end
    end

    // Tag and data arrays carry no reset; valid bits guard them.
    always_ff @(posedge clk) begin
        if (w_we) begin
            r_data[{w_fill_idx, w_beat}] <= i_mem_rdata;
            if (w_last) begin
                r_tag[w_fill_idx] <= w_fill_tag;
            end
        end
    end

endmodule

// File: tb/tb_instruction_cache.sv
module tb_instruction_cache;

    localparam int unsigned WPL = 4;

    logic        clk;
    logic        rst_n;
    logic        cpu_req;
    logic [31:0] cpu_addr;
    logic [31:0] cpu_rdata;
    logic        cpu_ready;
    logic        flush;
    logic [31:0] mem_addr;
    logic        mem_req;
    logic [31:0] mem_rdata;
    logic        mem_ready;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] exp_q[$];

    // Memory model: ready asserts after `lat` waiting cycles of a request;
    // `stale` additionally holds ready high while no request is outstanding.
    int   lat   = 4;
    bit   stale = 1'b0;
    int   cnt;
    logic ready_core;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    assign ready_core = mem_req && (cnt == lat);
    assign mem_ready  = ready_core || (stale && !mem_req);
    assign mem_rdata  = mem_word(mem_addr);

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= 0;
        else if (mem_req && !ready_core) cnt <= cnt + 1;
        else cnt <= 0;
    end

    instruction_cache #(
        .NUM_LINES      (64),
        .WORDS_PER_LINE (WPL)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_cpu_req   (cpu_req),
        .i_cpu_addr  (cpu_addr),
        .o_cpu_rdata (cpu_rdata),
        .o_cpu_ready (cpu_ready),
        .i_flush     (flush),
        .o_mem_addr  (mem_addr),
        .o_mem_req   (mem_req),
        .i_mem_rdata (mem_rdata),
        .i_mem_ready (mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Sample point of the current cycle; also scores accepted refill beats.
    task automatic half();
        logic [31:0] e;
        @(negedge clk);
        if (mem_req && mem_ready) begin
            chk("beat_expected", 32'(exp_q.size() > 0), 32'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("mem_addr", mem_addr, e);
            end
        end
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [31:0] a);
        logic [31:0] base;
        base = a & ~32'(WPL * 4 - 1);
        for (int k = 0; k < WPL; k++) exp_q.push_back(base + 32'(4 * k));
    endtask

    // Fetch `a`; miss=1 expects a refill (and pushes its beats), stall>=0
    // checks the exact number of stall cycles.
    task automatic fetch(input logic [31:0] a, input bit miss, input int stall,
                         input string tag);
        int n;
        n = 0;
        cpu_req  = 1'b1;
        cpu_addr = a;
        if (miss) push_line(a);
        half();
        while (!cpu_ready && n < 400) begin
            n++;
            adv();
            half();
        end
        chk({tag, "_ready"}, 32'(cpu_ready), 32'd1);
        chk({tag, "_data"}, cpu_rdata, mem_word(a & ~32'd3));
        if (miss) begin
            chk({tag, "_stalled"}, 32'(n > 0), 32'd1);
            chk({tag, "_beats_left"}, 32'(exp_q.size()), 32'd0);
        end else begin
            chk({tag, "_hit_latency"}, 32'(n), 32'd0);
        end
        if (stall >= 0) chk({tag, "_stall_cycles"}, 32'(n), 32'(stall));
        adv();
        cpu_req = 1'b0;
    endtask

    initial begin
        int n;
        rst_n    = 1'b0;
        cpu_req  = 1'b0;
        cpu_addr = 32'd0;
        flush    = 1'b0;
        #1;
        chk("rst_cpu_ready", 32'(cpu_ready), 32'd0);
        chk("rst_cpu_rdata", cpu_rdata, 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        adv();
        adv();
        rst_n = 1'b1;
        adv();

        // Cold miss, then the rest of the line hits.
        fetch(32'h0000_0100, 1'b1, 24, "cold");
        fetch(32'h0000_0104, 1'b0, 0, "hit104");
        fetch(32'h0000_0108, 1'b0, 0, "hit108");
        fetch(32'h0000_010C, 1'b0, 0, "hit10c");

        // Conflict on index 16.
        fetch(32'h0000_0500, 1'b1, 24, "conflict500");
        fetch(32'h0000_0100, 1'b1, 24, "conflict100");
        fetch(32'h0000_0100, 1'b0, 0, "rehit100");

        // Flush in IDLE.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0100;
        flush    = 1'b1;
        half();
        chk("flush_idle_same", 32'(cpu_ready), 32'd0);
        adv();
        flush = 1'b0;
        half();
        chk("flush_idle_next", 32'(cpu_ready), 32'd0);
        adv();
        fetch(32'h0000_0100, 1'b1, -1, "flush_refetch");

        // Flush during beat 2 of a refill of 0x200.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0200;
        push_line(32'h0000_0200);
        n = 0;
        half();
        while (!(mem_req && mem_addr == 32'h0000_0208) && n < 200) begin
            n++;
            adv();
            half();
        end
        chk("beat2_reached", mem_addr, 32'h0000_0208);
        adv();
        flush = 1'b1;
        half();
        adv();
        flush = 1'b0;
        half();
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            n++;
            adv();
            half();
        end
        chk("flush_refill_done", 32'(exp_q.size()), 32'd0);
        adv();
        half();
        chk("flush_pend_ready", 32'(cpu_ready), 32'd0);
        adv();
        fetch(32'h0000_0200, 1'b1, -1, "flush_pend_refetch");

        // Stale ready held high in the gap cycles.
        stale = 1'b1;
        lat   = 2;
        fetch(32'h0000_2000, 1'b1, 16, "stale");
        fetch(32'h0000_2004, 1'b0, 0, "stale_w1");
        fetch(32'h0000_2008, 1'b0, 0, "stale_w2");
        fetch(32'h0000_200C, 1'b0, 0, "stale_w3");
        stale = 1'b0;

        // Fastest memory.
        lat = 0;
        fetch(32'h0000_4008, 1'b1, 8, "lat_min");
        lat = 4;

        // Reset during beat 1.
        cpu_req  = 1'b1;
        cpu_addr = 32'h0000_0300;
        push_line(32'h0000_0300);
        n = 0;
        half();
        while (!(mem_req && mem_addr == 32'h0000_0304) && n < 200) begin
            n++;
            adv();
            half();
        end
        chk("beat1_reached", mem_addr, 32'h0000_0304);
        adv();
        rst_n = 1'b0;
        #1;
        chk("rst_mid_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mid_cpu_ready", 32'(cpu_ready), 32'd0);
        exp_q.delete();
        cpu_req = 1'b0;
        adv();
        adv();
        rst_n = 1'b1;
        adv();
        fetch(32'h0000_0300, 1'b1, 24, "post_reset");
        fetch(32'h0000_0100, 1'b1, 24, "post_reset_cleared");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
